// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter: one Avalon-MM master port shared by three CPU requestors.
// The requestors are the data-cache write buffer drain, the data-cache read miss
// and instruction fetch. One bus transaction is in flight at a time. A data read
// is held back until the write buffer is empty, so it never overtakes a buffered
// write.
module mips_avalon_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_write,
   input  logic [31:0] wb_addr,
   input  logic [31:0] wb_writedata,
   input  logic [3:0]  wb_byteenable,
   input  logic        wb_empty,
   output logic        wb_waitrequest,
   input  logic        dr_read,
   input  logic [31:0] dr_addr,
   input  logic [3:0]  dr_byteenable,
   output logic        dr_waitrequest,
   output logic [31:0] dr_readdata,
   input  logic        ir_read,
   input  logic [31:0] ir_addr,
   output logic        ir_waitrequest,
   output logic [31:0] ir_readdata,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic [1:0]  state_out
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_READ_D = 2'd2,
      ST_READ_I = 2'd3
   } state_t;

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   state_t      state_q, state_d;
   state_t      grant_s;
   logic        last_wr_q, last_wr_d;
   logic [31:0] avm_address_q, avm_address_d;
   logic        avm_read_q, avm_read_d;
   logic        avm_write_q, avm_write_d;
   logic [31:0] avm_writedata_q, avm_writedata_d;
   logic [3:0]  avm_byteenable_q, avm_byteenable_d;
   logic        wr_elig_s, dr_elig_s, ir_elig_s;

   // Pick the winning requestor from the current requests and the fairness flag.
   always_comb begin
      wr_elig_s = wb_write;
      dr_elig_s = dr_read & wb_empty;
      ir_elig_s = ir_read;
      grant_s   = ST_IDLE;
      if (!last_wr_q) begin
         if (wr_elig_s) begin
            grant_s = ST_WRITE;
         end else if (dr_elig_s) begin
            grant_s = ST_READ_D;
         end else if (ir_elig_s) begin
            grant_s = ST_READ_I;
         end else begin
            grant_s = ST_IDLE;
         end
      end else begin
         if (dr_elig_s) begin
            grant_s = ST_READ_D;
         end else if (ir_elig_s) begin
            grant_s = ST_READ_I;
         end else if (wr_elig_s) begin
            grant_s = ST_WRITE;
         end else begin
            grant_s = ST_IDLE;
         end
      end
   end

   // Next state: capture the granted request in IDLE, return to IDLE on completion.
   always_comb begin
      state_d          = state_q;
      last_wr_d        = last_wr_q;
      avm_address_d    = avm_address_q;
      avm_read_d       = avm_read_q;
      avm_write_d      = avm_write_q;
      avm_writedata_d  = avm_writedata_q;
      avm_byteenable_d = avm_byteenable_q;
      case (state_q)
         ST_IDLE: begin
            case (grant_s)
               ST_WRITE: begin
                  state_d          = ST_WRITE;
                  last_wr_d        = 1'b1;
                  avm_address_d    = wb_addr & WORD_MASK;
                  avm_writedata_d  = wb_writedata;
                  avm_byteenable_d = wb_byteenable;
                  avm_write_d      = 1'b1;
                  avm_read_d       = 1'b0;
               end
               ST_READ_D: begin
                  state_d          = ST_READ_D;
                  last_wr_d        = 1'b0;
                  avm_address_d    = dr_addr & WORD_MASK;
                  avm_byteenable_d = dr_byteenable;
                  avm_read_d       = 1'b1;
                  avm_write_d      = 1'b0;
               end
               ST_READ_I: begin
                  state_d          = ST_READ_I;
                  last_wr_d        = 1'b0;
                  avm_address_d    = ir_addr & WORD_MASK;
                  avm_byteenable_d = 4'hF;
                  avm_read_d       = 1'b1;
                  avm_write_d      = 1'b0;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
         ST_WRITE, ST_READ_D, ST_READ_I: begin
            if (!avm_waitrequest) begin
               state_d     = ST_IDLE;
               avm_read_d  = 1'b0;
               avm_write_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            avm_read_d  = 1'b0;
            avm_write_d = 1'b0;
         end
      endcase
   end

   // State and bus-side output registers; reset may abort a transaction at any time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_IDLE;
         last_wr_q        <= 1'b0;
         avm_address_q    <= 32'h0000_0000;
         avm_read_q       <= 1'b0;
         avm_write_q      <= 1'b0;
         avm_writedata_q  <= 32'h0000_0000;
         avm_byteenable_q <= 4'h0;
      end else begin
         state_q          <= state_d;
         last_wr_q        <= last_wr_d;
         avm_address_q    <= avm_address_d;
         avm_read_q       <= avm_read_d;
         avm_write_q      <= avm_write_d;
         avm_writedata_q  <= avm_writedata_d;
         avm_byteenable_q <= avm_byteenable_d;
      end
   end

   assign avm_address    = avm_address_q;
   assign avm_read       = avm_read_q;
   assign avm_write      = avm_write_q;
   assign avm_writedata  = avm_writedata_q;
   assign avm_byteenable = avm_byteenable_q;
   assign state_out      = state_q;

   // Only the owner of the current transaction sees waitrequest drop, and only
   // in the cycle the bus completes it.
   assign wb_waitrequest = !((state_q == ST_WRITE)  && !avm_waitrequest);
   assign dr_waitrequest = !((state_q == ST_READ_D) && !avm_waitrequest);
   assign ir_waitrequest = !((state_q == ST_READ_I) && !avm_waitrequest);
   assign dr_readdata    = avm_readdata;
   assign ir_readdata    = avm_readdata;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Bench for mips_avalon_arbiter: directed scenarios with literal expectations,
// then randomized requestors checked every cycle against a transaction-level model.
module tb_mips_avalon_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wb_write = 1'b0;
   logic [31:0] wb_addr = 32'h0;
   logic [31:0] wb_writedata = 32'h0;
   logic [3:0]  wb_byteenable = 4'h0;
   logic        wb_empty = 1'b1;
   logic        wb_waitrequest;
   logic        dr_read = 1'b0;
   logic [31:0] dr_addr = 32'h0;
   logic [3:0]  dr_byteenable = 4'h0;
   logic        dr_waitrequest;
   logic [31:0] dr_readdata;
   logic        ir_read = 1'b0;
   logic [31:0] ir_addr = 32'h0;
   logic        ir_waitrequest;
   logic [31:0] ir_readdata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = 32'h0;
   logic [1:0]  state_out;

   mips_avalon_arbiter dut (
      .clk(clk), .rst(rst),
      .wb_write(wb_write), .wb_addr(wb_addr), .wb_writedata(wb_writedata),
      .wb_byteenable(wb_byteenable), .wb_empty(wb_empty), .wb_waitrequest(wb_waitrequest),
      .dr_read(dr_read), .dr_addr(dr_addr), .dr_byteenable(dr_byteenable),
      .dr_waitrequest(dr_waitrequest), .dr_readdata(dr_readdata),
      .ir_read(ir_read), .ir_addr(ir_addr), .ir_waitrequest(ir_waitrequest),
      .ir_readdata(ir_readdata),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .state_out(state_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Transaction-level model: kind 0 none, 1 write, 2 data read, 3 fetch.
   bit          m_busy = 1'b0;
   int          m_kind = 0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   logic [3:0]  m_be = 4'h0;
   bit          m_last_wr = 1'b0;

   // Random requestor bookkeeping.
   bit rand_mode = 1'b0;
   int wb_cnt = 0;
   bit wb_need_head = 1'b0;
   bit dr_pend = 1'b0;
   bit ir_pend = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy    = 1'b0;
      m_kind    = 0;
      m_last_wr = 1'b0;
   endtask

   function automatic bit eligible(input int k);
      case (k)
         1: return wb_write;
         2: return dr_read && wb_empty;
         3: return ir_read;
         default: return 1'b0;
      endcase
   endfunction

   task automatic grant(input int k);
      m_busy = 1'b1;
      m_kind = k;
      case (k)
         1: begin m_addr = {wb_addr[31:2], 2'b00}; m_be = wb_byteenable; m_wdata = wb_writedata; m_last_wr = 1'b1; end
         2: begin m_addr = {dr_addr[31:2], 2'b00}; m_be = dr_byteenable; m_last_wr = 1'b0; end
         default: begin m_addr = {ir_addr[31:2], 2'b00}; m_be = 4'hF; m_last_wr = 1'b0; end
      endcase
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_update();
      int order[3];
      if (m_busy) begin
         if (!avm_waitrequest) begin
            m_busy = 1'b0;
            if (rand_mode) begin
               case (m_kind)
                  1: begin wb_cnt--; wb_need_head = 1'b1; end
                  2: dr_pend = 1'b0;
                  default: ir_pend = 1'b0;
               endcase
            end
         end
      end else begin
         if (m_last_wr) order = '{2, 3, 1};
         else           order = '{1, 2, 3};
         for (int i = 0; i < 3; i++) begin
            if (!m_busy && eligible(order[i])) grant(order[i]);
         end
      end
   endtask

   // Check all DUT outputs against the model for the current cycle.
   task automatic compare_model();
      bit done;
      chk("state_out", {30'd0, state_out}, m_busy ? m_kind : 0);
      chk("avm_read", {31'd0, avm_read}, {31'd0, m_busy && m_kind != 1});
      chk("avm_write", {31'd0, avm_write}, {31'd0, m_busy && m_kind == 1});
      if (m_busy) begin
         chk("avm_address", avm_address, m_addr);
         chk("avm_byteenable", {28'd0, avm_byteenable}, {28'd0, m_be});
         if (m_kind == 1) chk("avm_writedata", avm_writedata, m_wdata);
      end
      done = m_busy && !avm_waitrequest;
      chk("wb_waitrequest", {31'd0, wb_waitrequest}, {31'd0, !(done && m_kind == 1)});
      chk("dr_waitrequest", {31'd0, dr_waitrequest}, {31'd0, !(done && m_kind == 2)});
      chk("ir_waitrequest", {31'd0, ir_waitrequest}, {31'd0, !(done && m_kind == 3)});
      if (done && m_kind == 2) chk("dr_readdata", dr_readdata, avm_readdata);
      if (done && m_kind == 3) chk("ir_readdata", ir_readdata, avm_readdata);
   endtask

   // One clock: compare near the start of the cycle, step model at the edge, return at negedge.
   task automatic step();
      #1;
      if (!rst) model_reset();
      compare_model();
      @(posedge clk);
      if (rst) model_update();
      else     model_reset();
      @(negedge clk);
   endtask

   task automatic drive_random();
      if (wb_cnt < 4 && $urandom_range(0, 5) == 0) begin
         if (wb_cnt == 0) wb_need_head = 1'b1;
         wb_cnt++;
      end
      if (wb_need_head && wb_cnt > 0) begin
         wb_addr       = $urandom;
         wb_writedata  = $urandom;
         wb_byteenable = 4'($urandom);
         wb_need_head  = 1'b0;
      end
      wb_write = (wb_cnt > 0);
      wb_empty = (wb_cnt == 0);
      if (!dr_pend && $urandom_range(0, 3) == 0) begin
         dr_pend       = 1'b1;
         dr_addr       = $urandom;
         dr_byteenable = 4'($urandom);
      end
      dr_read = dr_pend;
      if (!ir_pend && $urandom_range(0, 3) == 0) begin
         ir_pend = 1'b1;
         ir_addr = $urandom;
      end
      ir_read = ir_pend;
      avm_waitrequest = ($urandom_range(0, 2) == 0);
      avm_readdata    = $urandom;
   endtask

   task automatic clear_inputs();
      wb_write = 1'b0; wb_empty = 1'b1; dr_read = 1'b0; ir_read = 1'b0;
      avm_waitrequest = 1'b0; avm_readdata = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   initial begin
      int seq[8];
      @(negedge clk);
      // Reset state.
      #1;
      chk("rst_state", {30'd0, state_out}, 32'd0);
      chk("rst_avm_read", {31'd0, avm_read}, 32'd0);
      chk("rst_avm_write", {31'd0, avm_write}, 32'd0);
      chk("rst_avm_address", avm_address, 32'h0);
      chk("rst_avm_writedata", avm_writedata, 32'h0);
      chk("rst_avm_byteenable", {28'd0, avm_byteenable}, 32'h0);
      chk("rst_wb_wait", {31'd0, wb_waitrequest}, 32'd1);
      chk("rst_dr_wait", {31'd0, dr_waitrequest}, 32'd1);
      chk("rst_ir_wait", {31'd0, ir_waitrequest}, 32'd1);
      do_reset();

      // Single write, zero-wait bus.
      wb_write = 1'b1; wb_empty = 1'b0; wb_addr = 32'h1000_0007;
      wb_writedata = 32'hDEAD_BEEF; wb_byteenable = 4'b0011;
      step();
      wb_write = 1'b0; wb_empty = 1'b1;
      #1;
      chk("wr_avm_write", {31'd0, avm_write}, 32'd1);
      chk("wr_avm_address", avm_address, 32'h1000_0004);
      chk("wr_avm_writedata", avm_writedata, 32'hDEAD_BEEF);
      chk("wr_avm_byteenable", {28'd0, avm_byteenable}, 32'h3);
      chk("wr_wb_wait_low", {31'd0, wb_waitrequest}, 32'd0);
      step();
      #1;
      chk("wr_wb_wait_high", {31'd0, wb_waitrequest}, 32'd1);
      chk("wr_idle", {30'd0, state_out}, 32'd0);

      // Ordering: buffered write drains before the data read.
      do_reset();
      wb_write = 1'b1; wb_empty = 1'b0; dr_read = 1'b1; dr_addr = 32'h0000_2000; dr_byteenable = 4'hF;
      step();
      #1;
      chk("ord_first_is_write", {30'd0, state_out}, 32'd1);
      chk("ord_dr_stalled", {31'd0, dr_waitrequest}, 32'd1);
      wb_write = 1'b0; wb_empty = 1'b1;
      step();
      step();
      avm_readdata = 32'h1234_5678;
      #1;
      chk("ord_read_state", {30'd0, state_out}, 32'd2);
      chk("ord_read_addr", avm_address, 32'h0000_2000);
      chk("ord_dr_readdata", dr_readdata, 32'h1234_5678);
      chk("ord_dr_wait_low", {31'd0, dr_waitrequest}, 32'd0);
      step();
      dr_read = 1'b0;
      clear_inputs();

      // Fairness: write and fetch held high alternate.
      do_reset();
      wb_write = 1'b1; wb_empty = 1'b0; wb_addr = 32'h0000_0100; ir_read = 1'b1; ir_addr = 32'h0000_0200;
      for (int i = 0; i < 8; i++) begin
         step();
         seq[i] = state_out;
      end
      chk("fair_0", seq[0], 32'd1);
      chk("fair_2", seq[2], 32'd3);
      chk("fair_4", seq[4], 32'd1);
      chk("fair_6", seq[6], 32'd3);
      chk("fair_gap", seq[1] + seq[3] + seq[5] + seq[7], 32'd0);
      clear_inputs();

      // Bus stall on a fetch: five wait cycles then completion.
      do_reset();
      ir_read = 1'b1; ir_addr = 32'hBFC0_0000; avm_waitrequest = 1'b1;
      step();
      ir_read = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         avm_waitrequest = (k < 6);
         #1;
         chk("stall_read", {31'd0, avm_read}, 32'd1);
         chk("stall_addr", avm_address, 32'hBFC0_0000);
         chk("stall_state", {30'd0, state_out}, 32'd3);
         chk("stall_ir_wait", {31'd0, ir_waitrequest}, (k == 6) ? 32'd0 : 32'd1);
         step();
      end
      clear_inputs();

      // Read priority: data read before fetch.
      do_reset();
      dr_read = 1'b1; dr_addr = 32'h0000_3000; dr_byteenable = 4'hF; ir_read = 1'b1; ir_addr = 32'h0000_4000;
      step();
      #1;
      chk("prio_dr_first", {30'd0, state_out}, 32'd2);
      chk("prio_ir_wait", {31'd0, ir_waitrequest}, 32'd1);
      step();
      dr_read = 1'b0;
      step();
      #1;
      chk("prio_ir_second", {30'd0, state_out}, 32'd3);
      chk("prio_ir_addr", avm_address, 32'h0000_4000);
      step();
      clear_inputs();

      // Reset while a fetch is stalled.
      do_reset();
      ir_read = 1'b1; ir_addr = 32'h0000_0040; avm_waitrequest = 1'b1;
      step();
      #1;
      chk("mid_in_read_i", {30'd0, state_out}, 32'd3);
      rst = 1'b0;
      #1;
      chk("mid_avm_read", {31'd0, avm_read}, 32'd0);
      chk("mid_state", {30'd0, state_out}, 32'd0);
      step();
      rst = 1'b1; ir_read = 1'b0;
      step();
      #1;
      chk("mid_ir_wait", {31'd0, ir_waitrequest}, 32'd1);
      clear_inputs();

      // Randomized traffic against the model.
      do_reset();
      rand_mode = 1'b1;
      wb_cnt = 0; dr_pend = 1'b0; ir_pend = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         drive_random();
         if (c == 1500) rst = 1'b0;
         else           rst = 1'b1;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_avalon_arbiter.md
# mips_avalon_arbiter

Single-master Avalon-MM arbiter between the CPU's three memory requestors and the system bus. It consumes the data-cache write buffer's drain port, the data-cache read-miss port and the instruction-fetch port, and issues one transaction at a time on one Avalon master port. It enforces write-before-read ordering for data: data reads never bypass buffered writes.

## Interface
Parameters
- none; all datapaths are 32-bit and all byteenables are 4-bit.

Ports
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset; one clock
- wb_write  in  1  write buffer has an entry presented (its write_writeenable)
- wb_addr  in  32  write address
- wb_writedata  in  32  write data
- wb_byteenable  in  4  write byteenable
- wb_empty  in  1  write buffer holds no entries
- wb_waitrequest  out  1  low for exactly the cycle the write completes on the bus
- dr_read  in  1  data read request, held until accepted
- dr_addr  in  32  data read address
- dr_byteenable  in  4  data read byteenable
- dr_waitrequest  out  1  low in the cycle dr_readdata is valid
- dr_readdata  out  32  data read result
- ir_read  in  1  instruction fetch request, held until accepted
- ir_addr  in  32  fetch address
- ir_waitrequest  out  1  low in the cycle ir_readdata is valid
- ir_readdata  out  32  fetch result
- avm_address  out  32  bus address, bits [1:0] forced to 0
- avm_read  out  1  bus read strobe
- avm_write  out  1  bus write strobe
- avm_writedata  out  32  bus write data
- avm_byteenable  out  4  bus byteenable
- avm_waitrequest  in  1  bus stall
- avm_readdata  in  32  bus read data, valid when avm_read && !avm_waitrequest
- state_out  out  2  current state, debug

## Operation
- States: IDLE=0, WRITE=1, READ_D=2, READ_I=3.
- Eligibility in IDLE:
  - write is eligible when wb_write=1;
  - data read when dr_read=1 && wb_empty=1;
  - fetch when ir_read=1.
- Fairness flag last_wr (reset 0) alternates between the write class and the read class. Within the read class, data read beats fetch.
  - last_wr=0: write, else data read, else fetch.
  - last_wr=1: data read, else fetch, else write.
- On grant: capture address/data/byteenable into output registers and go to the granted state. last_wr←1 for WRITE, 0 for either read.
- Fetch byteenable is always 4'hF. avm_address = {addr[31:2],2'b00}.
- Completion: in WRITE/READ_D/READ_I, the first cycle with avm_waitrequest=0 completes the transaction. At that edge: state←IDLE and avm_read/avm_write←0.
- Requestor waitrequests are combinational:
  - wb_waitrequest = !(state==WRITE && !avm_waitrequest); same pattern for dr/ir.
- dr_readdata and ir_readdata = avm_readdata (pass-through), valid only in their completion cycle.
- Requestor inputs are ignored outside the grant edge. Captured values are held stable for the whole transaction.
- Data read while wb_empty=0: it is not eligible, even when it is the only request. It waits until the buffer drains.
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE, last_wr=0;
  - avm_read=0, avm_write=0;
  - avm_address/avm_writedata=0, avm_byteenable=0;
  - all requestor waitrequests=1.
- An aborted bus transaction is not replayed.

## Timing
- Grant latency: request sampled in IDLE at edge N; avm_read/avm_write high from cycle N+1.
- Zero-wait bus: completion in cycle N+1; requestor sees waitrequest=0 in cycle N+1; IDLE in N+2.
- Minimum spacing between transactions: one IDLE cycle. No back-to-back grants.
- Never avm_read && avm_write simultaneously; at most one requestor waitrequest low per cycle.
- Write buffer retire: the buffer retires its entry at the edge where wb_waitrequest=0. The arbiter must never drive wb_waitrequest low while state≠WRITE.
- avm_* outputs are registered. Only the requestor waitrequest/readdata paths are combinational.

## Test plan
- Reset mid-read: assert rst low while state=READ_I with avm_waitrequest=1 → avm_read=0 within the same cycle, state_out=0, ir_waitrequest=1 after release.
- Single write: wb_write=1, wb_addr=0x1000_0007, data 0xDEADBEEF, be 4'b0011, avm_waitrequest=0 → next cycle avm_write=1, avm_address=0x1000_0004, writedata=0xDEADBEEF, be=0011, wb_waitrequest=0 for exactly 1 cycle.
- Ordering: wb_empty=0, wb_write=1, dr_read=1 at 0x2000 → write issued first, dr stays stalled. After wb_empty=1, avm_read to 0x2000; avm_readdata 0x12345678 appears on dr_readdata with dr_waitrequest=0.
- Fairness: wb_write and ir_read held high continuously, zero-wait bus → grants alternate WRITE, READ_I, WRITE, READ_I (last_wr starts 0).
- Bus stall: ir_read at 0xBFC0_0000, avm_waitrequest high for 5 cycles → avm_read/avm_address stable for 6 cycles, ir_waitrequest low only in the 6th; state_out=3 throughout.
- Priority in reads: dr_read and ir_read both high, wb_empty=1, no write → READ_D granted first, then READ_I; ir_readdata never valid during READ_D.
